// File: rtl/c4_pkg.sv
// rtl/c4_pkg.sv - cell codes, game status codes and controller state encoding for the drop controller
package c4_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_P1    = 2'b01,
    CELL_P2    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    ST_NEXT_TURN  = 2'b00,
    ST_PLAYER_WIN = 2'b01,
    ST_TIE_GAME   = 2'b10
  } status_t;

  typedef enum logic [2:0] {
    S_CLEAR  = 3'd0,
    S_IDLE   = 3'd1,
    S_SCAN   = 3'd2,
    S_WAIT   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHECK  = 3'd5,
    S_LOCKED = 3'd6
  } state_t;

  function automatic cell_t piece_for(input logic turn);
    return turn ? CELL_P2 : CELL_P1;
  endfunction

endpackage

// File: rtl/c4_drop_controller_if.sv
// rtl/c4_drop_controller_if.sv - move request, board RAM and win-checker signals of the drop controller
interface c4_drop_controller_if #(
  parameter int ROW_W = 3,
  parameter int COL_W = 3
);
  logic             move_valid;
  logic             move_ready;
  logic [COL_W-1:0] move_col;

  logic             mem_rd_en;
  logic             mem_wr_en;
  logic [ROW_W-1:0] mem_row;
  logic [COL_W-1:0] mem_col;
  logic [1:0]       mem_wr_data;
  logic [1:0]       mem_rd_data;

  logic             check_req;
  logic [ROW_W-1:0] check_row;
  logic [COL_W-1:0] check_col;
  logic             check_ack;
  logic             check_win;

  // master is the controller; slave is the decoder/RAM/win-checker side
  modport master (
    input  move_valid, move_col, mem_rd_data, check_ack, check_win,
    output move_ready, mem_rd_en, mem_wr_en, mem_row, mem_col, mem_wr_data,
           check_req, check_row, check_col
  );

  modport slave (
    output move_valid, move_col, mem_rd_data, check_ack, check_win,
    input  move_ready, mem_rd_en, mem_wr_en, mem_row, mem_col, mem_wr_data,
           check_req, check_row, check_col
  );
endinterface

// File: rtl/c4_col_height_table.sv
// rtl/c4_col_height_table.sv - per-column fill height, used only when C4_HEIGHT_CACHE_EN is defined
module c4_col_height_table #(
  parameter int ROWS  = 6,
  parameter int COLS  = 7,
  parameter int ROW_W = 3,
  parameter int COL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [COL_W-1:0] inc_col,
  input  logic [COL_W-1:0] rd_col,
  output logic [ROW_W:0]   height,
  output logic             full
);

  logic [ROW_W:0] tbl [COLS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < COLS; i++) tbl[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < COLS; i++) tbl[i] <= '0;
    end else if (inc && (int'(inc_col) < COLS)) begin
      tbl[inc_col] <= tbl[inc_col] + 1'b1;
    end
  end

  // out-of-range columns read as empty; the controller rejects them separately
  assign height = (int'(rd_col) < COLS) ? tbl[rd_col] : '0;
  assign full   = (height >= (ROW_W+1)'(ROWS));

endmodule

// File: rtl/c4_drop_controller.sv
// rtl/c4_drop_controller.sv - Connect-4 move sequencer: board clear, drop scan, write, win-check handoff
// Optional C4_HEIGHT_CACHE_EN replaces the RAM scan with a per-column height table.
module c4_drop_controller
  import c4_pkg::*;
#(
  parameter int ROWS  = 6,
  parameter int COLS  = 7,
  parameter int ROW_W = 3,
  parameter int COL_W = 3,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 new_game,
  c4_drop_controller_if.master bus,
  output logic                 player_turn,
  output logic                 invalid_move,
  output logic [1:0]           in_game_status,
  output logic [CNT_W-1:0]     move_count,
  output logic                 busy
);

  localparam logic [ROW_W-1:0] ROW_TOP = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_TOP = COL_W'(COLS - 1);
  localparam logic [CNT_W-1:0] CELLS   = CNT_W'(ROWS * COLS);

  state_t           state, state_n;
  status_t          status;
  logic [ROW_W-1:0] row_r, clr_row;
  logic [COL_W-1:0] col_r, clr_col;
  logic [CNT_W-1:0] count_inc;
  logic             col_ok, clr_last, cell_full, restart;

  assign col_ok    = (int'(bus.move_col) < COLS);
  assign clr_last  = (clr_row == ROW_TOP) && (clr_col == COL_TOP);
  assign cell_full = (bus.mem_rd_data != CELL_EMPTY);
  assign count_inc = move_count + CNT_W'(1);
  assign restart   = new_game && ((state == S_IDLE) || (state == S_LOCKED));

`ifdef C4_HEIGHT_CACHE_EN
  logic [ROW_W:0] col_height;
  logic           col_full;

  c4_col_height_table #(
    .ROWS (ROWS),
    .COLS (COLS),
    .ROW_W(ROW_W),
    .COL_W(COL_W)
  ) u_height (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == S_CLEAR),
    .inc    (state == S_WRITE),
    .inc_col(col_r),
    .rd_col (bus.move_col),
    .height (col_height),
    .full   (col_full)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_CLEAR: if (clr_last) state_n = S_IDLE;
      S_IDLE: begin
        if (restart) begin
          state_n = S_CLEAR;
        end else if (bus.move_valid && col_ok) begin
`ifdef C4_HEIGHT_CACHE_EN
          if (!col_full) state_n = S_WRITE;
`else
          state_n = S_SCAN;
`endif
        end
      end
      S_SCAN:  state_n = S_WAIT;
      S_WAIT: begin
        if (!cell_full)          state_n = S_WRITE;
        else if (row_r == ROW_TOP) state_n = S_IDLE;
        else                     state_n = S_SCAN;
      end
      S_WRITE: state_n = S_CHECK;
      S_CHECK: begin
        if (bus.check_ack) begin
          if (bus.check_win || (count_inc == CELLS)) state_n = S_LOCKED;
          else                                       state_n = S_IDLE;
        end
      end
      S_LOCKED: if (restart) state_n = S_CLEAR;
      default:  state_n = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_row      <= '0;
      clr_col      <= '0;
      row_r        <= '0;
      col_r        <= '0;
      player_turn  <= 1'b0;
      move_count   <= '0;
      status       <= ST_NEXT_TURN;
      invalid_move <= 1'b0;
    end else begin
      invalid_move <= 1'b0;
      if (restart) begin
        clr_row     <= '0;
        clr_col     <= '0;
        player_turn <= 1'b0;
        move_count  <= '0;
        status      <= ST_NEXT_TURN;
      end else begin
        case (state)
          S_CLEAR: begin
            if (clr_col == COL_TOP) begin
              clr_col <= '0;
              clr_row <= clr_last ? '0 : clr_row + 1'b1;
            end else begin
              clr_col <= clr_col + 1'b1;
            end
          end
          S_IDLE: begin
            if (bus.move_valid) begin
              col_r <= bus.move_col;
`ifdef C4_HEIGHT_CACHE_EN
              row_r <= col_height[ROW_W-1:0];
              if (!col_ok || col_full) invalid_move <= 1'b1;
`else
              row_r <= '0;
              if (!col_ok) invalid_move <= 1'b1;
`endif
            end
          end
          S_WAIT: begin
            if (cell_full) begin
              if (row_r == ROW_TOP) invalid_move <= 1'b1;
              else                  row_r <= row_r + 1'b1;
            end
          end
          S_CHECK: begin
            // a win freezes the turn so the winner stays visible on player_turn
            if (bus.check_ack) begin
              if (bus.check_win) begin
                status <= ST_PLAYER_WIN;
              end else begin
                move_count <= count_inc;
                if (count_inc == CELLS) begin
                  status <= ST_TIE_GAME;
                end else begin
                  status      <= ST_NEXT_TURN;
                  player_turn <= ~player_turn;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.move_ready  = (state == S_IDLE);
    bus.mem_rd_en   = 1'b0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_row     = '0;
    bus.mem_col     = '0;
    bus.mem_wr_data = CELL_EMPTY;
    bus.check_req   = 1'b0;
    bus.check_row   = '0;
    bus.check_col   = '0;
    case (state)
      S_CLEAR: begin
        // held off while reset is asserted so no strobe escapes during reset
        bus.mem_wr_en = ~reset;
        bus.mem_row   = clr_row;
        bus.mem_col   = clr_col;
      end
      S_SCAN: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_row   = row_r;
        bus.mem_col   = col_r;
      end
      S_WRITE: begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_row     = row_r;
        bus.mem_col     = col_r;
        bus.mem_wr_data = piece_for(player_turn);
      end
      S_CHECK: begin
        bus.check_req = 1'b1;
        bus.check_row = row_r;
        bus.check_col = col_r;
      end
      default: ;
    endcase
  end

  assign busy           = ~bus.move_ready;
  assign in_game_status = status;

endmodule

// File: tb/tb_c4_drop_controller.sv
// tb/tb_c4_drop_controller.sv - scoreboard bench for c4_drop_controller (scan and height-cache builds)
module tb_c4_drop_controller;
  localparam int ROWS = 6, COLS = 7, ROW_W = 3, COL_W = 3, CNT_W = 6;
`ifdef C4_HEIGHT_CACHE_EN
  localparam bit CACHED = 1'b1;
`else
  localparam bit CACHED = 1'b0;
`endif

  typedef enum int {EV_RD, EV_WR, EV_INV, EV_CHK} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       row;
    int       col;
    int       data;
    int       cyc;
  } ev_t;

  ev_t expq[$];

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             new_game = 1'b0;
  logic             player_turn, invalid_move, busy;
  logic [1:0]       in_game_status;
  logic [CNT_W-1:0] move_count;

  c4_drop_controller_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus();

  c4_drop_controller #(
    .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W), .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .new_game      (new_game),
    .bus           (bus),
    .player_turn   (player_turn),
    .invalid_move  (invalid_move),
    .in_game_status(in_game_status),
    .move_count    (move_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // board RAM with one-cycle read latency
  logic [1:0] board [8][8];
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= board[bus.mem_row][bus.mem_col];
    if (bus.mem_wr_en) board[bus.mem_row][bus.mem_col] <= bus.mem_wr_data;
  end

  int n_checks = 0;
  int n_pass = 0;
  int idle_viol = 0;
  bit chk_prev = 1'b0;
  int heights[COLS];
  bit m_turn;
  int m_count;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic expect_ev(input ev_kind_t k, input int r, input int c, input int d, input int t);
    ev_t e;
    e.kind = k; e.row = r; e.col = c; e.data = d; e.cyc = t;
    expq.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input int r, input int c, input int d);
    ev_t e;
    n_checks++;
    if (expq.size() == 0) begin
      $display("FAIL unexpected_%s: got (%0d,%0d) data %0d at cycle %0d, expected no event",
               k.name(), r, c, d, cyc);
      return;
    end
    e = expq.pop_front();
    if (e.kind == k && e.row == r && e.col == c && e.data == d && (e.cyc < 0 || e.cyc == cyc))
      n_pass++;
    else
      $display("FAIL event: got %s (%0d,%0d) data %0d cycle %0d, expected %s (%0d,%0d) data %0d cycle %0d",
               k.name(), r, c, d, cyc, e.kind.name(), e.row, e.col, e.data, e.cyc);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_rd_en) observe(EV_RD, int'(bus.mem_row), int'(bus.mem_col), 0);
      if (bus.mem_wr_en) observe(EV_WR, int'(bus.mem_row), int'(bus.mem_col), int'(bus.mem_wr_data));
      if (invalid_move)  observe(EV_INV, 0, 0, 0);
      if (bus.check_req && !chk_prev) observe(EV_CHK, int'(bus.check_row), int'(bus.check_col), 0);
      if (!bus.mem_rd_en && !bus.mem_wr_en &&
          (bus.mem_row != 0 || bus.mem_col != 0 || bus.mem_wr_data != 0)) idle_viol++;
      chk_prev = bus.check_req;
    end
  end

  task automatic wait_ready(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!bus.move_ready && n < 200) begin @(negedge clk); n++; end
    ok = bus.move_ready;
    if (!ok) begin
      n_checks++;
      $display("FAIL wait_ready: move_ready=%0d after 200 cycles, expected 1", bus.move_ready);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 100) begin @(negedge clk); n++; end
    #1;
    check("drain_queue", expq.size(), 0);
  endtask

  task automatic push_clear(input int start);
    for (int k = 0; k < ROWS * COLS; k++) expect_ev(EV_WR, k / COLS, k % COLS, 0, start + k);
    foreach (heights[i]) heights[i] = 0;
    m_turn = 1'b0;
    m_count = 0;
  endtask

  task automatic do_move(input int col, input bit win, input int ack_delay);
    bit ok;
    int a, h, w, piece, n;
    wait_ready(ok);
    if (!ok) return;
    bus.move_valid = 1'b1;
    bus.move_col   = COL_W'(col);
    @(posedge clk); #1;
    a = cyc;
    bus.move_valid = 1'b0;
    piece = m_turn ? 2 : 1;
    if (col >= COLS) begin
      expect_ev(EV_INV, 0, 0, 0, a);
      return;
    end
    h = heights[col];
    if (!CACHED)
      for (int k = 0; k <= h && k < ROWS; k++) expect_ev(EV_RD, k, col, 0, a + 2 * k);
    if (h >= ROWS) begin
      expect_ev(EV_INV, 0, 0, 0, CACHED ? a : a + 2 * ROWS);
      return;
    end
    w = CACHED ? a : a + 2 * (h + 1);
    expect_ev(EV_WR, h, col, piece, w);
    expect_ev(EV_CHK, h, col, 0, w + 1);
    n = 0;
    while (!bus.check_req && n < 50) begin @(negedge clk); n++; end
    if (!bus.check_req) begin
      check("check_req_timeout", bus.check_req, 1);
      return;
    end
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk);
      check("check_req_held", bus.check_req, 1);
    end
    @(posedge clk); #1;
    bus.check_ack = 1'b1;
    bus.check_win = win;
    @(posedge clk); #1;
    bus.check_ack = 1'b0;
    bus.check_win = 1'b0;
    check("check_req_drop", bus.check_req, 0);
    heights[col]++;
    if (!win) begin
      m_count++;
      if (m_count != ROWS * COLS) m_turn = !m_turn;
    end
  endtask

  initial begin
    int c0, e, held_ready;
    bit ok;
    bus.move_valid = 1'b0;
    bus.move_col   = '0;
    bus.check_ack  = 1'b0;
    bus.check_win  = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_player_turn", player_turn, 0);
    check("rst_move_count", move_count, 0);
    check("rst_status", in_game_status, 0);
    check("rst_wr_en", bus.mem_wr_en, 0);
    check("rst_rd_en", bus.mem_rd_en, 0);
    check("rst_check_req", bus.check_req, 0);
    check("rst_invalid", invalid_move, 0);

    // 1: power-on clear of all 42 cells
    @(posedge clk); #1;
    c0 = cyc;
    reset = 1'b0;
    push_clear(c0);
    wait_ready(ok);
    check("clear_cycles", cyc - c0, ROWS * COLS);
    check("ready_busy", busy, 0);

    // 2: first move on an empty board
    do_move(3, 1'b0, 3);
    check("t2_turn", player_turn, 1);
    check("t2_count", move_count, 1);
    check("t2_status", in_game_status, 0);

    // 3: fill column 2, then a move into the full column
    for (int i = 0; i < ROWS; i++) do_move(2, 1'b0, i % 3);
    do_move(2, 1'b0, 0);
    drain();
    check("t3_turn", player_turn, 1);
    check("t3_count", move_count, 7);

    // 4: out-of-range column
    do_move(7, 1'b0, 0);
    drain();
    check("t4_turn", player_turn, 1);
    check("t4_count", move_count, 7);

    // 5: P2 wins, board locks, new_game restarts
    do_move(0, 1'b1, 1);
    check("t5_status", in_game_status, 1);
    check("t5_turn", player_turn, 1);
    check("t5_count", move_count, 7);
    check("t5_locked", bus.move_ready, 0);
    held_ready = 0;
    bus.move_valid = 1'b1;
    bus.move_col   = 3'd4;
    repeat (6) begin @(negedge clk); held_ready += int'(bus.move_ready); end
    bus.move_valid = 1'b0;
    check("t5_ignored", held_ready, 0);
    @(posedge clk); #1;
    new_game = 1'b1;
    @(posedge clk); #1;
    e = cyc;
    new_game = 1'b0;
    push_clear(e);
    check("t5_ng_turn", player_turn, 0);
    check("t5_ng_count", move_count, 0);
    check("t5_ng_status", in_game_status, 0);
    wait_ready(ok);
    check("t5_clear_cycles", cyc - e, ROWS * COLS);

    // 6: 42 moves with no win ends in a tie
    for (int i = 0; i < ROWS * COLS; i++) begin
      do_move(i % COLS, 1'b0, i % 3);
      if (i == ROWS * COLS - 2) check("t6_status_41", in_game_status, 0);
    end
    check("t6_status", in_game_status, 2);
    check("t6_count", move_count, ROWS * COLS);
    check("t6_turn", player_turn, 1);
    check("t6_locked", bus.move_ready, 0);

    drain();
    check("idle_ports_zero", idle_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
